// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg
// Shared definitions for the counter sequencer slice: command opcodes,
// FSM state encoding and the default counter width.
// No ports (package).

package counter_seq_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Command opcodes carried on cmd_op.
  localparam logic [1:0] OP_UP     = 2'b00;
  localparam logic [1:0] OP_DOWN   = 2'b01;
  localparam logic [1:0] OP_BOUNCE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN_UP   = 3'd1,
    ST_RUN_DOWN = 3'd2,
    ST_BNC_UP   = 3'd3,
    ST_BNC_DOWN = 3'd4
  } state_e;

endpackage

// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if
// Command channel between a caller and the counter sequencer.
//   cmd_valid : caller has a command on cmd_op/cmd_limit
//   cmd_ready : sequencer is idle and will take the command
//   cmd_op    : opcode (see counter_seq_pkg)
//   cmd_limit : target / turn-around value
//   abort     : cancel the running command
// Handshake: a command transfers on a rising clock edge where cmd_valid and
// cmd_ready are both 1. The caller keeps cmd_valid, cmd_op and cmd_limit
// stable until that edge; cmd_valid seen while cmd_ready is 0 is neither
// acted on nor remembered.
// Modports: master = caller side, slave = sequencer side.

interface counter_sequencer_if #(
  parameter int WIDTH = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_limit;
  logic             abort;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_limit,
    output abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_limit,
    input  abort,
    output cmd_ready
  );

endinterface

// File: rtl/counter_step_unit.sv
// counter_step_unit
// The shared up/down counter register. Only the sequencer drives it.
// Ports:
//   clock   : rising-edge clock
//   clear_b : asynchronous active-high reset (count -> 0)
//   step_en : advance the count by one this edge
//   up      : direction of the step (1 = +1, 0 = -1)
//   clr     : synchronous clear to 0 (wins over step_en)
//   count   : current value, arithmetic modulo 2^WIDTH

module counter_step_unit
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             clear_b,
  input  logic             step_en,
  input  logic             up,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Plain +/-1 on a WIDTH-bit vector gives the modulo wrap for free.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (step_en) begin
      count_d = up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
    end
  end

  always_ff @(posedge clock or posedge clear_b) begin
    if (clear_b) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer
// Command-driven controller for the shared up/down counter. Takes one
// command at a time (UP, DOWN, BOUNCE, CLEAR), steps the counter until the
// limit is reached, then pulses done for one cycle. abort cancels a running
// command and pulses aborted instead.
// Ports:
//   clock      : rising-edge clock
//   clear_b    : asynchronous active-high reset
//   cmd        : command channel (counter_sequencer_if.slave)
//   count      : current counter value
//   dir_up     : 1 while stepping up
//   busy       : command in progress
//   done       : one-cycle completion pulse
//   aborted    : one-cycle cancellation pulse
//   state_dbg  : current FSM state (debug visibility)
// Build option:
//   COUNTER_SEQ_PRESCALE_EN : when defined, the counter steps once every
//   PRESCALE cycles instead of every cycle; abort still acts on the next edge.

module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = 4
) (
  input  logic               clock,
  input  logic               clear_b,
  counter_sequencer_if.slave cmd,
  output logic [WIDTH-1:0]   count,
  output logic               dir_up,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [2:0]         state_dbg
);

  localparam logic [2:0] S_IDLE     = 3'(ST_IDLE);
  localparam logic [2:0] S_RUN_UP   = 3'(ST_RUN_UP);
  localparam logic [2:0] S_RUN_DOWN = 3'(ST_RUN_DOWN);
  localparam logic [2:0] S_BNC_UP   = 3'(ST_BNC_UP);
  localparam logic [2:0] S_BNC_DOWN = 3'(ST_BNC_DOWN);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("counter_sequencer: PRESCALE must be >= 1");
  end

  logic [2:0]       state_q,     state_d;
  logic [WIDTH-1:0] limit_q,     limit_d;
  logic             done_q,      done_d;
  logic             aborted_q,   aborted_d;
  logic             cmd_ready_q, cmd_ready_d;

  logic             accept;
  logic             step_tick;
  logic             step_en;
  logic             step_up;
  logic             cnt_clr;
  logic             going_up;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] stepped;

  assign accept = cmd.cmd_valid && cmd_ready_q;

`ifdef COUNTER_SEQ_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0] ps_q, ps_d;

  // A step happens on the edge where the prescaler wraps back to zero.
  assign step_tick = (ps_q == PS_W'(PRESCALE - 1));

  // Prescaler only runs while a command is active; it restarts from zero on
  // acceptance (IDLE holds it at zero) and after an abort.
  always_comb begin
    ps_d = ps_q;
    if (state_q == S_IDLE || cmd.abort) begin
      ps_d = '0;
    end else if (step_tick) begin
      ps_d = '0;
    end else begin
      ps_d = ps_q + PS_W'(1);
    end
  end

  always_ff @(posedge clock or posedge clear_b) begin
    if (clear_b) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end
`else
  assign step_tick = 1'b1;
`endif

  // BNC_DOWN always heads for zero; every other running state heads for the
  // latched limit.
  assign going_up = (state_q == S_RUN_UP) || (state_q == S_BNC_UP);
  assign target   = (state_q == S_BNC_DOWN) ? '0 : limit_q;
  assign stepped  = going_up ? (count + WIDTH'(1)) : (count - WIDTH'(1));

  always_comb begin
    state_d   = state_q;
    limit_d   = limit_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    step_en   = 1'b0;
    step_up   = 1'b0;
    cnt_clr   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort is deliberately not looked at here.
        if (accept) begin
          limit_d = cmd.cmd_limit;
          case (cmd.cmd_op)
            OP_UP:     state_d = S_RUN_UP;
            OP_DOWN:   state_d = S_RUN_DOWN;
            // A zero turn-around point means there is no up phase at all.
            OP_BOUNCE: state_d = (cmd.cmd_limit == '0) ? S_BNC_DOWN : S_BNC_UP;
            default: begin
              cnt_clr = 1'b1;
              done_d  = 1'b1;
            end
          endcase
        end
      end

      S_RUN_UP, S_RUN_DOWN, S_BNC_UP, S_BNC_DOWN: begin
        if (cmd.abort) begin
          // Abort wins even over a step that would have finished the command.
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (step_tick) begin
          if (count != target) begin
            step_en = 1'b1;
            step_up = going_up;
          end
          // Finish either without stepping (already there) or on the step
          // that lands on the target.
          if ((count == target) || (stepped == target)) begin
            if (state_q == S_BNC_UP) begin
              state_d = S_BNC_DOWN;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clock or posedge clear_b) begin
    if (clear_b) begin
      state_q     <= S_IDLE;
      limit_q     <= '0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      limit_q     <= limit_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  counter_step_unit #(
    .WIDTH (WIDTH)
  ) u_step (
    .clock   (clock),
    .clear_b (clear_b),
    .step_en (step_en),
    .up      (step_up),
    .clr     (cnt_clr),
    .count   (count)
  );

  assign cmd.cmd_ready = cmd_ready_q;
  assign dir_up        = going_up;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer
// Directed bench for counter_sequencer. Each command that should end in a
// done/aborted pulse pushes the expected {done, aborted, count} into exp_q;
// a monitor on the falling edge pops and compares every pulse the DUT makes.
// Step-by-step count/dir_up/done checks are made inline by the driver.

module tb_counter_sequencer;
  import counter_seq_pkg::*;

  localparam int W = 4;
`ifdef COUNTER_SEQ_PRESCALE_EN
  localparam int STEP = 4;
`else
  localparam int STEP = 1;
`endif

  logic         clock;
  logic         clear_b;
  logic [W-1:0] count;
  logic         dir_up;
  logic         busy;
  logic         done;
  logic         aborted;
  logic [2:0]   state_dbg;

  counter_sequencer_if #(.WIDTH(W)) cmd_if ();

  counter_sequencer #(
    .WIDTH    (W),
    .PRESCALE (4)
  ) dut (
    .clock     (clock),
    .clear_b   (clear_b),
    .cmd       (cmd_if.slave),
    .count     (count),
    .dir_up    (dir_up),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W+1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_pulse(input bit is_done, input logic [W-1:0] c);
    exp_q.push_back({is_done, ~is_done, c});
  endtask

  always @(negedge clock) begin
    if (!clear_b && (done || aborted)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse: got done=%0b aborted=%0b count=%0d, required no pulse",
                 done, aborted, count);
      end else begin
        check("pulse_done_aborted_count", 32'({done, aborted, count}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [W-1:0] limit);
    int waited = 0;
    while (cmd_if.cmd_ready !== 1'b1 && waited < 100) begin
      edges(1);
      waited++;
    end
    if (waited >= 100) check("cmd_ready_timeout", 32'(cmd_if.cmd_ready), 32'd1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_limit = limit;
    edges(1);
    cmd_if.cmd_valid = 1'b0;
  endtask

  // dir_up is checked before the step edge, count/done after it.
  task automatic step_check(input string name, input logic [W-1:0] exp_count,
                            input logic exp_done, input logic exp_dir);
    check({name, "_dir_up"}, 32'(dir_up), 32'(exp_dir));
    edges(STEP);
    check({name, "_count"}, 32'(count), 32'(exp_count));
    check({name, "_done"}, 32'(done), 32'(exp_done));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_b          = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_UP;
    cmd_if.cmd_limit = '0;
    cmd_if.abort     = 1'b0;

    // Reset values, cmd_ready rises one edge after release.
    edges(2);
    check("rst_count", 32'(count), 32'd0);
    check("rst_cmd_ready", 32'(cmd_if.cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'({done, aborted}), 32'd0);
    check("rst_dir_up", 32'(dir_up), 32'd0);
    clear_b = 1'b0;
    check("ready_low_at_release", 32'(cmd_if.cmd_ready), 32'd0);
    edges(1);
    check("ready_after_release", 32'(cmd_if.cmd_ready), 32'd1);

    // UP limit=3 from 0.
    expect_pulse(1'b1, 4'd3);
    send_cmd(OP_UP, 4'd3);
    check("up3_busy", 32'(busy), 32'd1);
    check("up3_ready_low", 32'(cmd_if.cmd_ready), 32'd0);
    step_check("up3_s1", 4'd1, 1'b0, 1'b1);
    step_check("up3_s2", 4'd2, 1'b0, 1'b1);
    step_check("up3_s3", 4'd3, 1'b1, 1'b1);
    check("up3_ready_with_done", 32'(cmd_if.cmd_ready), 32'd1);
    check("up3_busy_end", 32'(busy), 32'd0);

    // Bring count to 14, then UP limit=2 wraps through 15,0,1,2.
    expect_pulse(1'b1, 4'd14);
    send_cmd(OP_UP, 4'd14);
    edges(11 * STEP);
    check("up14_count", 32'(count), 32'd14);
    check("up14_done", 32'(done), 32'd1);
    expect_pulse(1'b1, 4'd2);
    send_cmd(OP_UP, 4'd2);
    step_check("wrap_s1", 4'd15, 1'b0, 1'b1);
    step_check("wrap_s2", 4'd0, 1'b0, 1'b1);
    step_check("wrap_s3", 4'd1, 1'b0, 1'b1);
    step_check("wrap_s4", 4'd2, 1'b1, 1'b1);

    // CLEAR, then BOUNCE limit=2 from 0.
    expect_pulse(1'b1, 4'd0);
    send_cmd(OP_CLEAR, 4'd9);
    check("clr_count", 32'(count), 32'd0);
    check("clr_done", 32'(done), 32'd1);
    check("clr_ready", 32'(cmd_if.cmd_ready), 32'd1);
    expect_pulse(1'b1, 4'd0);
    send_cmd(OP_BOUNCE, 4'd2);
    step_check("bnc_s1", 4'd1, 1'b0, 1'b1);
    step_check("bnc_s2", 4'd2, 1'b0, 1'b1);
    step_check("bnc_s3", 4'd1, 1'b0, 1'b0);
    step_check("bnc_s4", 4'd0, 1'b1, 1'b0);

    // count=5, DOWN limit=5 is a zero-step command; then CLEAR.
    expect_pulse(1'b1, 4'd5);
    send_cmd(OP_UP, 4'd5);
    edges(5 * STEP);
    check("up5_count", 32'(count), 32'd5);
    expect_pulse(1'b1, 4'd5);
    send_cmd(OP_DOWN, 4'd5);
    step_check("down_zero", 4'd5, 1'b1, 1'b0);
    expect_pulse(1'b1, 4'd0);
    send_cmd(OP_CLEAR, 4'd0);
    check("clr2_count", 32'(count), 32'd0);
    check("clr2_done", 32'(done), 32'd1);

    // UP limit=9 aborted on the edge that would make count 4.
    expect_pulse(1'b0, 4'd3);
    send_cmd(OP_UP, 4'd9);
    step_check("abt_s1", 4'd1, 1'b0, 1'b1);
    step_check("abt_s2", 4'd2, 1'b0, 1'b1);
    step_check("abt_s3", 4'd3, 1'b0, 1'b1);
    cmd_if.abort = 1'b1;
    edges(1);
    cmd_if.abort = 1'b0;
    check("abt_count_hold", 32'(count), 32'd3);
    check("abt_aborted", 32'(aborted), 32'd1);
    check("abt_no_done", 32'(done), 32'd0);
    check("abt_ready", 32'(cmd_if.cmd_ready), 32'd1);
    edges(1);
    check("abt_pulse_one_cycle", 32'(aborted), 32'd0);

    // UP limit=15 from 3, reset asserted mid-cycle at count=6.
    send_cmd(OP_UP, 4'd15);
    edges(3 * STEP);
    check("mid_count6", 32'(count), 32'd6);
    #2;
    clear_b = 1'b1;
    #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_dir", 32'(dir_up), 32'd0);
    check("mid_rst_pulses", 32'({done, aborted}), 32'd0);
    check("mid_rst_ready", 32'(cmd_if.cmd_ready), 32'd0);
    edges(1);
    clear_b = 1'b0;

    // abort held over the acceptance edge is ignored in IDLE.
    expect_pulse(1'b1, 4'd2);
    cmd_if.abort = 1'b1;
    send_cmd(OP_UP, 4'd2);
    cmd_if.abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd1);
    step_check("ia_s1", 4'd1, 1'b0, 1'b1);
    step_check("ia_s2", 4'd2, 1'b1, 1'b1);

    // DOWN limit=14 from 2 wraps through 1,0,15,14.
    expect_pulse(1'b1, 4'd14);
    send_cmd(OP_DOWN, 4'd14);
    step_check("dwrap_s1", 4'd1, 1'b0, 1'b0);
    step_check("dwrap_s2", 4'd0, 1'b0, 1'b0);
    step_check("dwrap_s3", 4'd15, 1'b0, 1'b0);
    step_check("dwrap_s4", 4'd14, 1'b1, 1'b0);

    edges(4);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Command-driven controller for the shared up/down counter datapath. Accepts one counting command at a time over a valid/ready handshake, then steps the counter up, down, or up-then-down until a programmed limit is reached. Signals completion with a one-cycle done pulse. Sits between the control logic and the counter flops so that no caller drives up/down directly.

Parameters:
WIDTH, 4, counter width in bits; all count arithmetic is modulo 2^WIDTH
PRESCALE, 4, cycles per step when COUNTER_SEQ_PRESCALE_EN is defined (must be >= 1)

Ports:
clock  input  1  rising-edge clock
clear_b  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer idle and able to accept a command
cmd_op  input  2  command: 00 UP, 01 DOWN, 10 BOUNCE, 11 CLEAR
cmd_limit  input  WIDTH  target value for UP/DOWN; turn-around value for BOUNCE
abort  input  1  cancel the running command
count  output  WIDTH  current counter value
dir_up  output  1  1 while stepping up, 0 otherwise
busy  output  1  command in progress
done  output  1  one-cycle pulse: command completed
aborted  output  1  one-cycle pulse: command cancelled

Behaviour:
- Reset (clear_b high, asynchronous): state IDLE; count=0; dir_up=0; busy=0; done=0; aborted=0; cmd_ready=0.
- cmd_ready is registered. It rises at the first clock edge after clear_b falls.
- cmd_ready=1 exactly in IDLE. Accept on a clock edge with cmd_valid && cmd_ready; cmd_op/cmd_limit are latched at that edge.
- States: IDLE, RUN_UP, RUN_DOWN, BNC_UP, BNC_DOWN.
- Acceptance transitions:
  - UP→RUN_UP; DOWN→RUN_DOWN; BOUNCE→BNC_UP.
  - CLEAR: stays in IDLE; count←0 and done=1 at the acceptance edge; cmd_ready stays 1.
- busy=1 and cmd_ready=0 in every RUN/BNC state.
- RUN_UP, per step edge:
  - If count==limit: done=1, go to IDLE, no step.
  - Else count←count+1 (wraps 2^WIDTH-1→0). If the new value equals limit: done=1 and go to IDLE at the same edge.
- RUN_DOWN: mirror of RUN_UP with count−1 (wraps 0→2^WIDTH-1).
- BNC_UP: steps up as in RUN_UP. On reaching limit, go to BNC_DOWN (no done). BNC_DOWN steps down to 0, then done=1 and go to IDLE.
  - If limit==0 at acceptance, BNC_UP goes straight to BNC_DOWN.
- dir_up=1 in RUN_UP/BNC_UP, 0 otherwise.
- Latency: a command needing N steps asserts done on the Nth step edge after acceptance. A zero-step command asserts done on the first edge after acceptance. A new command can be accepted on the edge after done.
- done/aborted are registered. They are high for exactly one cycle and never high together.
- abort:
  - Sampled at step edges in non-IDLE states: go to IDLE, count holds (no step on that edge), aborted=1, done=0.
  - Abort beats a simultaneous final step.
  - Ignored in IDLE, including the acceptance edge.
- clear_b asserted mid-command: immediate return to reset values. The command is lost and no done/aborted pulse is produced.
- cmd_valid while busy: ignored and not queued. The caller holds it until cmd_ready.

Optional Feature:
COUNTER_SEQ_PRESCALE_EN
- Defined:
  - A prescale counter of width clog2(PRESCALE) runs only in non-IDLE states. It is cleared on acceptance, abort, and reset.
  - "Step edge" means the edge at which the prescaler wraps, i.e. every PRESCALE cycles. The first step is PRESCALE edges after acceptance.
  - abort acts at the next clock edge, not the next step edge.
- Undefined: every clock edge in a RUN/BNC state is a step edge, and PRESCALE is unused.

Decomposition:
- Package counter_seq_pkg:
  - op encodings OP_UP/OP_DOWN/OP_BOUNCE/OP_CLEAR
  - state enum
  - default WIDTH constant
- One sub-module, counter_step_unit:
  - holds the count register (async active-high reset)
  - inputs step_en, up, clr
  - output count, with modulo wrap
- The sequencer FSM drives counter_step_unit.

Test Plan:
- Reset then UP limit=3 from count=0 → cmd_ready rises 1 edge after reset release; count 1,2,3 on the 3 edges after acceptance; done pulses with count=3; cmd_ready=1 that cycle.
- count=14, UP limit=2 → count 15,0,1,2 (wrap); done on the 4th edge after acceptance.
- count=0, BOUNCE limit=2 → count 1,2,1,0; dir_up 1,1,0,0; done only at count=0 (4th edge).
- count=5, DOWN limit=5 → no change; done on the first edge after acceptance. Then CLEAR → count=0 and done at the acceptance edge.
- UP limit=9 from 0, abort high on the edge where count would become 4 → count holds 3; aborted=1; done never asserts; cmd_ready=1.
- UP limit=15, clear_b pulsed at count=6 → all outputs return to reset values asynchronously; no done. With COUNTER_SEQ_PRESCALE_EN and PRESCALE=4: UP limit=2 from 0 → steps at edges 4 and 8; done at edge 8.
